// File: rtl/barrel_shifter_pipe_if.sv
// Stream interface for barrel_shifter_pipe: operand side (in_*) and
// result side (out_*) handshakes bundled together. The slave modport is
// the shifter's view; the master modport is the source/consumer view.
interface barrel_shifter_pipe_if #(
    parameter int WIDTH = 8
);
    localparam int SHW = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [SHW-1:0]   in_amt;
    logic [1:0]       in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport master (
        output in_valid, in_data, in_amt, in_mode, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_amt, in_mode, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/barrel_shifter_pipe.sv
// Pipelined barrel shifter: stage k conditionally shifts by 2^k in one of
// four modes (LSL, LSR, ASR, ROR) and registers the result. log2(WIDTH)
// stages, one operation per cycle, valid/ready flow control with bubble
// collapsing so an empty stage always pulls from the stage behind it.
module barrel_shifter_pipe #(
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    barrel_shifter_pipe_if.slave  bus
);
    localparam int SHW = $clog2(WIDTH);

    localparam logic [1:0] MODE_LSL = 2'b00;
    localparam logic [1:0] MODE_LSR = 2'b01;
    localparam logic [1:0] MODE_ASR = 2'b10;
    localparam logic [1:0] MODE_ROR = 2'b11;

    // Single shift by a fixed distance; sh is a per-stage constant so each
    // stage collapses to one mux level plus the mode select.
    function automatic logic [WIDTH-1:0] f_shift(
        input logic [WIDTH-1:0] d,
        input logic [1:0]       mode,
        input int               sh
    );
        logic signed [WIDTH-1:0] v_sd;
        v_sd = d;
        case (mode)
            MODE_LSL: f_shift = d << sh;
            MODE_LSR: f_shift = d >> sh;
            MODE_ASR: f_shift = v_sd >>> sh;
            default:  f_shift = (d >> sh) | (d << (WIDTH - sh));
        endcase
    endfunction

    // Stage registers: valid, data, shift amount and mode travel together.
    logic [SHW-1:0]   r_vld;
    logic [WIDTH-1:0] r_data [SHW];
    logic [SHW-1:0]   r_amt  [SHW];
    logic [1:0]       r_mode [SHW];

    // Per-stage inputs (from the port for stage 0, else the previous stage).
    logic [SHW-1:0]   w_src_vld;
    logic [WIDTH-1:0] w_src_data [SHW];
    logic [SHW-1:0]   w_src_amt  [SHW];
    logic [1:0]       w_src_mode [SHW];
    logic [WIDTH-1:0] w_nxt_data [SHW];
    logic [SHW-1:0]   w_adv;

    // Route each stage's source: the operand port feeds stage 0.
    always_comb begin
        w_src_vld[0]  = bus.in_valid;
        w_src_data[0] = bus.in_data;
        w_src_amt[0]  = bus.in_amt;
        w_src_mode[0] = bus.in_mode;
        for (int k = 1; k < SHW; k++) begin
            w_src_vld[k]  = r_vld[k-1];
            w_src_data[k] = r_data[k-1];
            w_src_amt[k]  = r_amt[k-1];
            w_src_mode[k] = r_mode[k-1];
        end
    end

    // Stage k applies a 2^k shift only when bit k of the amount is set.
    always_comb begin
        for (int k = 0; k < SHW; k++) begin
            w_nxt_data[k] = w_src_amt[k][k]
                          ? f_shift(w_src_data[k], w_src_mode[k], 1 << k)
                          : w_src_data[k];
        end
    end

    // Advance chain from the output backwards: a stage moves when it is
    // empty (bubble collapse) or when the stage ahead of it moves.
    always_comb begin
        logic v_adv;
        v_adv = !r_vld[SHW-1] || bus.out_ready;
        for (int k = SHW - 1; k >= 0; k--) begin
            if (k < SHW - 1) begin
                v_adv = !r_vld[k] || v_adv;
            end
            w_adv[k] = v_adv;
        end
    end

    assign bus.in_ready  = w_adv[0];
    assign bus.out_valid = r_vld[SHW-1];
    assign bus.out_data  = r_data[SHW-1];

    // Pipeline registers; payload only loads when a valid operand moves in,
    // so a stalled last stage holds out_data stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= '0;
            for (int k = 0; k < SHW; k++) begin
                r_data[k] <= '0;
                r_amt[k]  <= '0;
                r_mode[k] <= '0;
            end
        end else begin
            for (int k = 0; k < SHW; k++) begin
                if (w_adv[k]) begin
                    r_vld[k] <= w_src_vld[k];
                    if (w_src_vld[k]) begin
                        r_data[k] <= w_nxt_data[k];
                        r_amt[k]  <= w_src_amt[k];
                        r_mode[k] <= w_src_mode[k];
                    end
                end
            end
        end
    end
endmodule
